tconv_layer_sequencer: RTL and testbench

Top-level sequencer for the transpose-convolution engine. It walks a programmed range of layers, and every batch within each layer. For each batch it launches the per-batch scheduler, waits for it to finish, then triggers and waits for the output-buffer drain before moving to the next batch. It sits between the host/control register block and the per-batch scheduler, and provides watchdog timeout and abort handling.

---
 rtl/tconv_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_tconv_layer_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tconv_layer_sequencer.sv
// Layer/batch sequencer for the transpose-convolution engine: launches the
// per-batch scheduler, then the output drain, for every batch of a layer range.
module tconv_layer_sequencer #(
  parameter int L0_BATCHES     = 8,
  parameter int L1_BATCHES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] first_layer,
  input  logic [1:0] last_layer,
  input  logic       abort,
  input  logic       sched_done,
  input  logic       drain_done,
  output logic       sched_start,
  output logic [1:0] sched_layer_id,
  output logic [2:0] sched_batch_id,
  output logic       drain_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [4:0] batches_done
);

  typedef enum logic [2:0] {
    IDLE, LAUNCH, WAIT_SCHED, DRAIN, WAIT_DRAIN, NEXT, FINISH, ERR
  } state_t;

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_r;
  logic [1:0]  last_layer_r;
  logic [15:0] watchdog_r;
  logic        cfg_ok_s;
  logic        timeout_s;
  logic        batch_last_s;

  // Index of the final batch in a layer; anything above layer 0 uses the layer-1 count.
  function automatic logic [2:0] last_batch(input logic [1:0] layer);
    case (layer)
      2'd0:    last_batch = 3'(L0_BATCHES - 1);
      default: last_batch = 3'(L1_BATCHES - 1);
    endcase
  endfunction

  // Start-config validity, watchdog expiry and end-of-layer detection.
  always_comb begin
    cfg_ok_s     = (first_layer <= last_layer) && (last_layer <= 2'd1);
    timeout_s    = (watchdog_r == WD_LIMIT);
    batch_last_s = (sched_batch_id >= last_batch(sched_layer_id));
  end

  // Sequencer FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= IDLE;
      last_layer_r   <= 2'd0;
      watchdog_r     <= 16'd0;
      sched_start    <= 1'b0;
      sched_layer_id <= 2'd0;
      sched_batch_id <= 3'd0;
      drain_start    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= 2'd0;
      batches_done   <= 5'd0;
    end else begin
      sched_start <= 1'b0;
      drain_start <= 1'b0;
      done        <= 1'b0;
      if (abort) begin
        // Abort wins over every other event; error status and counters are kept.
        if (state_r != IDLE) begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE, ERR: begin
            if (start) begin
              busy <= 1'b1;
              if (cfg_ok_s) begin
                state_r        <= LAUNCH;
                last_layer_r   <= last_layer;
                sched_layer_id <= first_layer;
                sched_batch_id <= 3'd0;
                batches_done   <= 5'd0;
                error          <= 1'b0;
                err_code       <= 2'd0;
                sched_start    <= 1'b1;
              end else begin
                state_r  <= ERR;
                error    <= 1'b1;
                err_code <= 2'd1;
              end
            end
          end
          LAUNCH: begin
            state_r    <= WAIT_SCHED;
            watchdog_r <= 16'd0;
          end
          WAIT_SCHED: begin
            if (sched_done) begin
              state_r     <= DRAIN;
              drain_start <= 1'b1;
            end else if (timeout_s) begin
              state_r  <= ERR;
              error    <= 1'b1;
              err_code <= 2'd2;
            end else begin
              watchdog_r <= watchdog_r + 16'd1;
            end
          end
          DRAIN: begin
            state_r    <= WAIT_DRAIN;
            watchdog_r <= 16'd0;
          end
          WAIT_DRAIN: begin
            if (drain_done) begin
              state_r <= NEXT;
              if (batches_done != 5'd31) begin
                batches_done <= batches_done + 5'd1;
              end
            end else if (timeout_s) begin
              state_r  <= ERR;
              error    <= 1'b1;
              err_code <= 2'd3;
            end else begin
              watchdog_r <= watchdog_r + 16'd1;
            end
          end
          NEXT: begin
            if (!batch_last_s) begin
              sched_batch_id <= sched_batch_id + 3'd1;
              state_r        <= LAUNCH;
              sched_start    <= 1'b1;
            end else if (sched_layer_id < last_layer_r) begin
              sched_layer_id <= sched_layer_id + 2'd1;
              sched_batch_id <= 3'd0;
              state_r        <= LAUNCH;
              sched_start    <= 1'b1;
            end else begin
              state_r <= FINISH;
              done    <= 1'b1;
            end
          end
          FINISH: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tconv_layer_sequencer.sv
// Randomized self-checking bench for tconv_layer_sequencer against a
// layer/batch list model.
module tb_tconv_layer_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] first_layer;
  logic [1:0] last_layer;
  logic       abort;
  logic       sched_done;
  logic       drain_done;
  logic       sched_start;
  logic [1:0] sched_layer_id;
  logic [2:0] sched_batch_id;
  logic       drain_start;
  logic       busy;
  logic       done;
  logic       error;
  logic [1:0] err_code;
  logic [4:0] batches_done;

  int n_checks = 0;
  int n_fail   = 0;
  int launch_cnt = 0;
  int drain_cnt  = 0;
  int done_cnt   = 0;

  tconv_layer_sequencer #(
    .L0_BATCHES(8),
    .L1_BATCHES(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .first_layer(first_layer),
    .last_layer(last_layer),
    .abort(abort),
    .sched_done(sched_done),
    .drain_done(drain_done),
    .sched_start(sched_start),
    .sched_layer_id(sched_layer_id),
    .sched_batch_id(sched_batch_id),
    .drain_start(drain_start),
    .busy(busy),
    .done(done),
    .error(error),
    .err_code(err_code),
    .batches_done(batches_done)
  );

  always #5 clk = ~clk;

  // Pulse counters: each one-cycle pulse is seen exactly once at the edge ending it.
  always @(posedge clk) begin
    if (sched_start) launch_cnt++;
    if (drain_start) drain_cnt++;
    if (done) done_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic wait_for(input bit sel, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 64 && !seen; n++) begin
      seen = sel ? drain_start : sched_start;
      if (!seen) @(negedge clk);
    end
  endtask

  function automatic int batches_of(input int layer);
    return (layer == 0) ? 8 : 4;
  endfunction

  // One run over [fl, ll]; abort_idx >= 0 aborts together with that launch's sched_done.
  task automatic run(input logic [1:0] fl, input logic [1:0] ll, input int abort_idx, input bit spurious);
    int  q_layer[$];
    int  q_batch[$];
    int  n_exp;
    int  l0, dr0, dn0;
    bit  seen;
    for (int l = int'(fl); l <= int'(ll); l++)
      for (int b = 0; b < batches_of(l); b++) begin
        q_layer.push_back(l);
        q_batch.push_back(b);
      end
    n_exp = q_layer.size();
    l0 = launch_cnt; dr0 = drain_cnt; dn0 = done_cnt;
    first_layer = fl; last_layer = ll; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n_exp; i++) begin
      wait_for(1'b0, seen);
      check_eq("launch_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check_eq("launch_layer", 32'(sched_layer_id), 32'(q_layer[i]));
      check_eq("launch_batch", 32'(sched_batch_id), 32'(q_batch[i]));
      check_eq("launch_error", 32'(error), 32'd0);
      check_eq("launch_busy", 32'(busy), 32'd1);
      if (spurious && i == 0) begin
        @(negedge clk);
        first_layer = 2'd1; last_layer = 2'd0; start = 1'b1; drain_done = 1'b1;
        @(negedge clk);
        start = 1'b0; drain_done = 1'b0;
        check_eq("spur_error", 32'(error), 32'd0);
        check_eq("spur_no_drain", 32'(drain_cnt - dr0), 32'd0);
      end
      repeat ($urandom_range(1, 5)) @(negedge clk);
      if (i == abort_idx) begin
        sched_done = 1'b1; abort = 1'b1;
        @(negedge clk);
        sched_done = 1'b0; abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_batches", 32'(batches_done), 32'(abort_idx));
        dr0 = drain_cnt; dn0 = done_cnt; l0 = launch_cnt;
        repeat (6) @(negedge clk);
        check_eq("abort_no_drain", 32'(drain_cnt - dr0), 32'd0);
        check_eq("abort_no_done", 32'(done_cnt - dn0), 32'd0);
        check_eq("abort_no_launch", 32'(launch_cnt - l0), 32'd0);
        return;
      end
      sched_done = 1'b1;
      @(negedge clk);
      sched_done = 1'b0;
      wait_for(1'b1, seen);
      check_eq("drain_seen", 32'(seen), 32'd1);
      if (!seen) return;
      check_eq("drain_layer", 32'(sched_layer_id), 32'(q_layer[i]));
      check_eq("drain_batch", 32'(sched_batch_id), 32'(q_batch[i]));
      repeat ($urandom_range(1, 5)) @(negedge clk);
      drain_done = 1'b1;
      @(negedge clk);
      drain_done = 1'b0;
    end
    check_eq("done_early", 32'(done), 32'd0);
    @(negedge clk);
    check_eq("done_pulse", 32'(done), 32'd1);
    check_eq("run_batches", 32'(batches_done), 32'(n_exp));
    @(negedge clk);
    check_eq("done_width", 32'(done), 32'd0);
    check_eq("end_busy", 32'(busy), 32'd0);
    check_eq("run_launches", 32'(launch_cnt - l0), 32'(n_exp));
    check_eq("run_drains", 32'(drain_cnt - dr0), 32'(n_exp));
    check_eq("run_dones", 32'(done_cnt - dn0), 32'd1);
  endtask

  task automatic bad_cfg(input logic [1:0] fl, input logic [1:0] ll);
    int l0;
    l0 = launch_cnt;
    first_layer = fl; last_layer = ll; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("bad_error", 32'(error), 32'd1);
    check_eq("bad_code", 32'(err_code), 32'd1);
    check_eq("bad_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("bad_no_launch", 32'(launch_cnt - l0), 32'd0);
    check_eq("bad_held", 32'(error), 32'd1);
  endtask

  task automatic abort_err(input logic [1:0] code);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_err_busy", 32'(busy), 32'd0);
    check_eq("abort_err_error", 32'(error), 32'd1);
    check_eq("abort_err_code", 32'(err_code), 32'(code));
  endtask

  // Withholds the scheduler (drain_stage = 0) or drain (drain_stage = 1) response.
  task automatic timeout_case(input bit drain_stage);
    first_layer = 2'd0; last_layer = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("to_launch", 32'(sched_start), 32'd1);
    check_eq("to_cleared", 32'(error), 32'd0);
    if (drain_stage) begin
      @(negedge clk);
      sched_done = 1'b1;
      @(negedge clk);
      sched_done = 1'b0;
      check_eq("to_drain_start", 32'(drain_start), 32'd1);
    end
    repeat (16) @(negedge clk);
    check_eq("to_not_yet", 32'(error), 32'd0);
    @(negedge clk);
    check_eq("to_error", 32'(error), 32'd1);
    check_eq("to_code", 32'(err_code), drain_stage ? 32'd3 : 32'd2);
    check_eq("to_busy", 32'(busy), 32'd1);
  endtask

  initial begin
    logic [1:0] fl, ll;
    int n, ai;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sched_done = 1'b0; drain_done = 1'b0;
    first_layer = 2'd0; last_layer = 2'd0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_code", 32'(err_code), 32'd0);
    check_eq("rst_pulses", 32'({sched_start, drain_start, done}), 32'd0);
    check_eq("rst_ids", 32'({sched_layer_id, sched_batch_id}), 32'd0);
    check_eq("rst_batches", 32'(batches_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sched_done = 1'b1; drain_done = 1'b1;
    @(negedge clk);
    sched_done = 1'b0; drain_done = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("idle_spur_busy", 32'(busy), 32'd0);
    check_eq("idle_spur_drain", 32'(drain_cnt), 32'd0);

    run(2'd0, 2'd0, -1, 1'b0);
    run(2'd0, 2'd1, -1, 1'b0);
    bad_cfg(2'd1, 2'd0);
    abort_err(2'd1);
    run(2'd0, 2'd0, -1, 1'b0);
    timeout_case(1'b0);
    abort_err(2'd2);
    timeout_case(1'b1);
    run(2'd1, 2'd1, -1, 1'b0);
    run(2'd0, 2'd1, 10, 1'b0);
    run(2'd0, 2'd1, -1, 1'b1);

    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        do begin
          fl = 2'($urandom_range(0, 3));
          ll = 2'($urandom_range(0, 3));
        end while (fl <= ll && ll <= 2'd1);
        bad_cfg(fl, ll);
        abort_err(2'd1);
      end else begin
        fl = 2'($urandom_range(0, 1));
        ll = 2'($urandom_range(int'(fl), 1));
        n = 0;
        for (int l = int'(fl); l <= int'(ll); l++) n += batches_of(l);
        ai = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
        run(fl, ll, ai, 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
